// File: rtl/spi_frame_deserializer.sv
// Receive side of the ADC serial link: oversamples sclk/spi_cs/mosi on clkin, rebuilds
// LSB-first words, tags them with their frame index and checks frame integrity.
module spi_frame_deserializer #(
   parameter int WORD_BITS       = 12,
   parameter int WORDS_PER_FRAME = 16,
   parameter int WIDX_W          = 5,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                 clkin,
   input  logic                 rst_bar,
   input  logic                 sclk,
   input  logic                 spi_cs,
   input  logic                 mosi,
   output logic [WORD_BITS-1:0] out_data,
   output logic [WIDX_W-1:0]    out_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 frame_done,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int BC_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [BC_W-1:0]   BIT_LAST  = BC_W'(WORD_BITS - 1);
   localparam logic [WIDX_W-1:0] WORDS_MAX = WIDX_W'(WORDS_PER_FRAME);

   typedef enum logic {IDLE, RECV} state_t;

   // Handshake: a word transfers on any clkin edge with out_valid & out_ready both high;
   // out_data/out_idx hold while out_valid=1 and out_ready=0.
   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, settle;
   logic                   sclk_prev, cs_prev;
   logic [BC_W-1:0]        bitcnt;
   logic [WIDX_W-1:0]      wordcnt;
   logic [WORD_BITS-1:0]   shift;
   logic                   extra_seen;

   logic sclk_s, cs_s, mosi_s, sync_ok;
   logic cs_fall, cs_rise, sclk_rise;
   logic [WORD_BITS-1:0] word_next;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sync_ok   = settle[SYNC_STAGES-1];
   assign cs_fall   = cs_prev & ~cs_s;
   assign cs_rise   = ~cs_prev & cs_s;
   assign sclk_rise = ~sclk_prev & sclk_s;
   assign word_next = {mosi_s, shift[WORD_BITS-2:0]};

   // The chains reset to idle levels; cs_prev only tracks cs once the chain has flushed,
   // so a frame already running at reset release never produces a falling edge.
   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         sclk_sync <= '1;
         cs_sync   <= '1;
         mosi_sync <= '0;
         settle    <= '0;
         sclk_prev <= 1'b1;
         cs_prev   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
         sclk_prev <= sclk_s;
         cs_prev   <= sync_ok ? cs_s : 1'b0;
      end
   end

   always_ff @(posedge clkin or negedge rst_bar) begin
      if (!rst_bar) begin
         state      <= IDLE;
         bitcnt     <= '0;
         wordcnt    <= '0;
         shift      <= '0;
         extra_seen <= 1'b0;
         out_data   <= '0;
         out_idx    <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state      <= RECV;
                  busy       <= 1'b1;
                  bitcnt     <= '0;
                  wordcnt    <= '0;
                  shift      <= '0;
                  extra_seen <= 1'b0;
                  overrun    <= 1'b0;
               end
            end
            RECV: begin
               // cs_rise takes priority over a coincident sclk edge.
               if (cs_rise) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  frame_err  <= (bitcnt != '0) || (wordcnt != WORDS_MAX) || extra_seen;
                  bitcnt     <= '0;
               end else if (sclk_rise && !cs_s) begin
                  shift[bitcnt] <= mosi_s;
                  if (bitcnt == BIT_LAST) begin
                     bitcnt <= '0;
                     if (wordcnt < WORDS_MAX) begin
                        if (!out_valid || out_ready) begin
                           out_data  <= word_next;
                           out_idx   <= wordcnt;
                           out_valid <= 1'b1;
                        end else begin
                           overrun <= 1'b1;
                        end
                        wordcnt <= wordcnt + WIDX_W'(1);
                     end else begin
                        extra_seen <= 1'b1;
                     end
                  end else begin
                     bitcnt <= bitcnt + BC_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_deserializer.sv
// Directed bench for spi_frame_deserializer: drives framed LSB-first words at clkin/4 and
// scoreboards every handshake transfer against hand-built expected words.
module tb_spi_frame_deserializer;

   logic        clkin = 1'b0;
   logic        rst_bar;
   logic        sclk, spi_cs, mosi;
   logic [11:0] out_data;
   logic [4:0]  out_idx;
   logic        out_valid, out_ready;
   logic        frame_done, frame_err, overrun, busy;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int rx_cnt   = 0;
   logic last_err = 1'b0;
   logic [16:0] exp_q[$];

   spi_frame_deserializer dut (
      .clkin(clkin), .rst_bar(rst_bar), .sclk(sclk), .spi_cs(spi_cs), .mosi(mosi),
      .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
      .frame_done(frame_done), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );

   // clock / reset
   always #5 clkin = ~clkin;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard / monitor, sampled 1 ns after the falling edge
   always @(negedge clkin) begin
      #1;
      if (out_valid && out_ready) begin
         rx_cnt++;
         if (exp_q.size() == 0)
            check_eq("unexpected_word", {15'b0, out_idx, out_data}, 32'h1ffff);
         else
            check_eq("word", {15'b0, out_idx, out_data}, {15'b0, exp_q.pop_front()});
      end
      if (frame_done) begin
         done_cnt++;
         last_err = frame_err;
      end
   end

   // driver tasks
   task automatic push_exp(input int idx, input logic [11:0] w);
      logic [4:0] i5;
      i5 = 5'(idx);
      exp_q.push_back({i5, w});
   endtask

   task automatic cs_low();
      @(negedge clkin);
      spi_cs = 1'b0;
      repeat (4) @(negedge clkin);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clkin);
      sclk = 1'b0;
      mosi = b;
      @(negedge clkin);
      @(negedge clkin);
      sclk = 1'b1;
      @(negedge clkin);
   endtask

   task automatic send_word(input logic [11:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) send_bit(w[i]);
   endtask

   task automatic end_frame(input string tag, input logic exp_err, input bit raised);
      int d0;
      if (!raised) begin
         repeat (4) @(negedge clkin);
         spi_cs = 1'b1;
      end
      d0 = done_cnt;
      for (int i = 0; i < 30 && done_cnt == d0; i++) @(negedge clkin);
      repeat (3) @(negedge clkin);
      check_eq({tag, "_done"}, done_cnt - d0, 1);
      check_eq({tag, "_err"}, last_err, exp_err);
      check_eq({tag, "_left"}, exp_q.size(), 0);
      check_eq({tag, "_busy"}, busy, 0);
      repeat (4) @(negedge clkin);
   endtask

   initial begin
      int d0, r0;
      rst_bar   = 1'b0;
      sclk      = 1'b1;
      spi_cs    = 1'b1;
      mosi      = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clkin);
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_idx", out_idx, 0);
      check_eq("rst_done", frame_done, 0);
      check_eq("rst_err", frame_err, 0);
      check_eq("rst_overrun", overrun, 0);
      check_eq("rst_busy", busy, 0);
      rst_bar = 1'b1;
      repeat (6) @(negedge clkin);

      // nominal frame 0x001..0x010
      for (int w = 0; w < 16; w++) push_exp(w, 12'(w + 1));
      cs_low();
      check_eq("t1_busy", busy, 1);
      for (int w = 0; w < 16; w++) send_word(12'(w + 1), 12);
      end_frame("t1", 1'b0, 1'b0);
      check_eq("t1_overrun", overrun, 0);

      // bit order
      push_exp(0, 12'hA5C);
      for (int w = 1; w < 16; w++) push_exp(w, 12'hFFF);
      cs_low();
      send_word(12'hA5C, 12);
      for (int w = 1; w < 16; w++) send_word(12'hFFF, 12);
      end_frame("t2", 1'b0, 1'b0);

      // backpressure: word 1 lost, word 0 held, delivery resumes at idx 2
      out_ready = 1'b0;
      push_exp(0, 12'h001);
      for (int w = 2; w < 16; w++) push_exp(w, 12'(w + 1));
      cs_low();
      send_word(12'h001, 12);
      send_word(12'h002, 12);
      repeat (4) @(negedge clkin);
      check_eq("t3_hold_valid", out_valid, 1);
      check_eq("t3_hold_data", out_data, 12'h001);
      check_eq("t3_hold_idx", out_idx, 0);
      check_eq("t3_overrun", overrun, 1);
      out_ready = 1'b1;
      for (int w = 2; w < 16; w++) send_word(12'(w + 1), 12);
      end_frame("t3", 1'b0, 1'b0);
      check_eq("t3_overrun_sticky", overrun, 1);

      // short frame: 5 words + 7 bits; its cs_fall also clears overrun
      for (int w = 0; w < 5; w++) push_exp(w, 12'(12'h100 + w));
      cs_low();
      check_eq("t4_overrun_clr", overrun, 0);
      for (int w = 0; w < 5; w++) send_word(12'(12'h100 + w), 12);
      send_word(12'h3FF, 7);
      end_frame("t4a", 1'b1, 1'b0);

      // long frame: 17 words, 16 delivered
      for (int w = 0; w < 16; w++) push_exp(w, 12'(12'h800 + w));
      cs_low();
      for (int w = 0; w < 17; w++) send_word(12'(12'h800 + w), 12);
      end_frame("t4b", 1'b1, 1'b0);

      // reset mid word 3 with word 2 held
      push_exp(0, 12'h0AA);
      push_exp(1, 12'h0BB);
      cs_low();
      send_word(12'h0AA, 12);
      send_word(12'h0BB, 12);
      repeat (4) @(negedge clkin);
      out_ready = 1'b0;
      send_word(12'h0CC, 12);
      send_word(12'h0DD, 6);
      check_eq("t5_pre_valid", out_valid, 1);
      check_eq("t5_pre_data", out_data, 12'h0CC);
      d0 = done_cnt;
      r0 = rx_cnt;
      rst_bar = 1'b0;
      #1;
      check_eq("t5_rst_valid", out_valid, 0);
      check_eq("t5_rst_data", out_data, 0);
      check_eq("t5_rst_idx", out_idx, 0);
      check_eq("t5_rst_busy", busy, 0);
      send_word(12'h0DD, 3);
      rst_bar = 1'b1;
      out_ready = 1'b1;
      for (int w = 0; w < 3; w++) send_word(12'h555, 12);
      spi_cs = 1'b1;
      repeat (20) @(negedge clkin);
      check_eq("t5_no_done", done_cnt - d0, 0);
      check_eq("t5_no_words", rx_cnt - r0, 0);
      check_eq("t5_idle", busy, 0);
      for (int w = 0; w < 16; w++) push_exp(w, 12'(12'h4C0 + 3 * w));
      cs_low();
      for (int w = 0; w < 16; w++) send_word(12'(12'h4C0 + 3 * w), 12);
      end_frame("t5", 1'b0, 1'b0);

      // cs rise coincident with the 12th sclk rise of word 15
      for (int w = 0; w < 15; w++) push_exp(w, 12'(12'h200 + w));
      cs_low();
      for (int w = 0; w < 15; w++) send_word(12'(12'h200 + w), 12);
      send_word(12'hFFF, 11);
      @(negedge clkin);
      sclk = 1'b0;
      mosi = 1'b1;
      @(negedge clkin);
      @(negedge clkin);
      sclk   = 1'b1;
      spi_cs = 1'b1;
      end_frame("t6", 1'b1, 1'b1);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
